lm_sm_reg_sequencer: RTL and testbench

- Generates the register-address and memory-address sequence for load-multiple (LM) and store-multiple (SM) instructions.
- Walks an 8-bit register mask from R0 to R7. Each cycle it presents the current 3-bit register index on reg_addr, which feeds the data inputs and select of the 3-bit 8:1 register-address mux ahead of the register file.
- Driven by the multicycle control FSM through a start/step handshake. Reports completion with a one-cycle done pulse.

---
 rtl/lm_sm_reg_sequencer.sv | 148 ++++++++++++++
 tb/tb_lm_sm_reg_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_reg_sequencer.sv
// Register/memory address sequencer for load-multiple and store-multiple.
// Latency: start -> first valid reg_addr/mem_addr is 1 cycle; one register per step.
// Backpressure: step=0 holds the current register/address indefinitely; start is ignored while busy.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, mask, base_addr: begin a sequence; mask and base latched in IDLE only
//   step                  : current transfer finished, advance to the next set bit
//   reg_addr, mem_addr    : current register index and its memory address
//   valid, last           : outputs meaningful / current register is the final one
//   busy, done, empty_mask: sequence active / one-cycle completion pulse / mask was zero
// Optional (LMSM_WRITEBACK_EN): wb_valid pulses with done, wb_addr is base + ADDR_STEP*popcount(mask).
module lm_sm_reg_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              step,
  output logic [2:0]        reg_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              valid,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              empty_mask
`ifdef LMSM_WRITEBACK_EN
  ,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              empty_q, empty_d;

  logic [2:0]        low_idx;
  logic              one_left;
  logic              run;

  // Lowest set bit of the remaining mask; scanning downward lets bit 0 win.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_q[i]) low_idx = 3'(i);
    end
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign one_left = (rem_q != 8'd0) && ((rem_q & (rem_q - 8'd1)) == 8'd0);
  assign run      = (state_q == S_RUN);

`ifdef LMSM_WRITEBACK_EN
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]        pop_cnt;

  always_comb begin
    pop_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop_cnt = pop_cnt + {3'd0, mask[i]};
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    empty_d = empty_q;
`ifdef LMSM_WRITEBACK_EN
    wb_addr_d = wb_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = mask;
          addr_d  = base_addr;
          empty_d = (mask == 8'd0);
          state_d = (mask == 8'd0) ? S_DONE : S_RUN;
`ifdef LMSM_WRITEBACK_EN
          wb_addr_d = base_addr + ADDR_W'(ADDR_STEP * int'(pop_cnt));
`endif
        end
      end
      S_RUN: begin
        if (step) begin
          rem_d  = rem_q & (rem_q - 8'd1);
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          if (one_left) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      addr_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      empty_q <= empty_d;
    end
  end

`ifdef LMSM_WRITEBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr_q <= '0;
    end else begin
      wb_addr_q <= wb_addr_d;
    end
  end

  assign wb_valid = (state_q == S_DONE);
  assign wb_addr  = wb_addr_q;
`endif

  assign valid      = run;
  assign reg_addr   = run ? low_idx : 3'd0;
  assign last       = run && one_left;
  // Address register is visible at all times so it holds its final value after DONE.
  assign mem_addr   = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign empty_mask = (state_q == S_DONE) && empty_q;

endmodule

// File: tb/tb_lm_sm_reg_sequencer.sv
// Directed bench for lm_sm_reg_sequencer with a transfer scoreboard and a completion scoreboard.
module tb_lm_sm_reg_sequencer;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    mask = 8'd0;
  logic [AW-1:0] base_addr = '0;
  logic          step = 1'b0;
  logic [2:0]    reg_addr;
  logic [AW-1:0] mem_addr;
  logic          valid, last, busy, done, empty_mask;
`ifdef LMSM_WRITEBACK_EN
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
`endif

  lm_sm_reg_sequencer #(.ADDR_W(AW), .ADDR_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .base_addr(base_addr),
    .step(step), .reg_addr(reg_addr), .mem_addr(mem_addr), .valid(valid),
    .last(last), .busy(busy), .done(done), .empty_mask(empty_mask)
`ifdef LMSM_WRITEBACK_EN
    , .wb_valid(wb_valid), .wb_addr(wb_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    r;
    logic [AW-1:0] a;
    logic          l;
  } xfer_t;

  typedef struct packed {
    logic          e;
    logic [AW-1:0] a;
  } done_t;

  xfer_t xq[$];
  done_t dq[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected transfers for an arbitrary mask: set bits ascending, addresses incrementing.
  task automatic push_seq(input logic [7:0] m, input logic [AW-1:0] b);
    int k;
    int n;
    k = 0;
    n = $countones(m);
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        xq.push_back('{r: 3'(i), a: b + AW'(k), l: (k == n - 1)});
        k++;
      end
    end
    dq.push_back('{e: (m == 8'd0), a: b + AW'(n)});
  endtask

  // Sampled on the falling edge: compare the scoreboard front, pop only when step will be taken.
  always @(negedge clk) begin
    done_t d;
    if (rst_n) begin
      if (valid) begin
        if (xq.size() == 0) begin
          chk("unexpected_valid", {31'd0, valid}, 32'd0);
        end else begin
          chk("reg_addr", {29'd0, reg_addr}, {29'd0, xq[0].r});
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, xq[0].a});
          chk("last", {31'd0, last}, {31'd0, xq[0].l});
          chk("busy_run", {31'd0, busy}, 32'd1);
          if (step) void'(xq.pop_front());
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          d = dq.pop_front();
          chk("done_empty_mask", {31'd0, empty_mask}, {31'd0, d.e});
          chk("done_mem_addr", {16'd0, mem_addr}, {16'd0, d.a});
          chk("done_valid_low", {31'd0, valid}, 32'd0);
          chk("done_busy", {31'd0, busy}, 32'd1);
`ifdef LMSM_WRITEBACK_EN
          chk("wb_addr", {16'd0, wb_addr}, {16'd0, d.a});
`endif
        end
      end else begin
        chk("empty_mask_no_done", {31'd0, empty_mask}, 32'd0);
      end
`ifdef LMSM_WRITEBACK_EN
      chk("wb_valid_with_done", {31'd0, wb_valid}, {31'd0, done});
`endif
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reg_addr"}, {29'd0, reg_addr}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_last"}, {31'd0, last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_empty"}, {31'd0, empty_mask}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Sparse mask, step every cycle
    xq.push_back('{r: 3'd0, a: 16'h0040, l: 1'b0});
    xq.push_back('{r: 3'd2, a: 16'h0041, l: 1'b0});
    xq.push_back('{r: 3'd5, a: 16'h0042, l: 1'b0});
    xq.push_back('{r: 3'd7, a: 16'h0043, l: 1'b1});
    dq.push_back('{e: 1'b0, a: 16'h0044});
    mask = 8'b1010_0101; base_addr = 16'h0040; step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid_latency", {31'd0, valid}, 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("done_cycle", cyc, 32'd5);
    step = 1'b0;
    tick();
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("sparse_drained", xq.size(), 32'd0);

    // Zero mask, started in the IDLE cycle straight after done
    mask = 8'h00; base_addr = 16'h1234; start = 1'b1;
    dq.push_back('{e: 1'b1, a: 16'h1234});
    tick();
    start = 1'b0;
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_flag", {31'd0, empty_mask}, 32'd1);
    chk("empty_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("empty_idle_busy", {31'd0, busy}, 32'd0);
    chk("empty_idle_done", {31'd0, done}, 32'd0);

    // Single top bit, stalled step, address wrap
    xq.push_back('{r: 3'd7, a: 16'hFFFF, l: 1'b1});
    dq.push_back('{e: 1'b0, a: 16'h0000});
    mask = 8'h80; base_addr = 16'hFFFF; step = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("stall_valid", {31'd0, valid}, 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("wrap_done", {31'd0, done}, 32'd1);
    chk("wrap_mem_addr", {16'd0, mem_addr}, 32'h0000);
    tick();
    chk("wrap_hold_idle", {16'd0, mem_addr}, 32'h0000);

    // start during RUN (together with step) must not re-latch
    push_seq(8'b0100_0010, 16'h0200);
    mask = 8'b0100_0010; base_addr = 16'h0200; step = 1'b1; start = 1'b1;
    tick();
    mask = 8'hFF; base_addr = 16'h0999;
    tick();
    start = 1'b0;
    cyc = 2;
    while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("restart_ignored_done_cycle", cyc, 32'd3);
    step = 1'b0;
    tick();
    chk("restart_drained", xq.size(), 32'd0);

    // Low nibble; also exercises the writeback address when enabled
    push_seq(8'h0F, 16'h0100);
    mask = 8'h0F; base_addr = 16'h0100; step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("nibble_done_cycle", cyc, 32'd5);
`ifdef LMSM_WRITEBACK_EN
    chk("nibble_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("nibble_wb_addr", {16'd0, wb_addr}, 32'h0104);
`endif
    step = 1'b0;
    tick();

    // Asynchronous reset in the middle of a full-mask sequence
    push_seq(8'hFF, 16'h0000);
    mask = 8'hFF; base_addr = 16'h0000; step = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    xq.delete();
    dq.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
